// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between execute stage and data memory.
//   Parameter MEM_DEPTH : data-memory depth in 32-bit words (power of two).
//   Optional macro DATA_BOUNDS_CHECK_EN : reject reqAddress >= MEM_DEPTH with respError
//     instead of wrapping the address modulo MEM_DEPTH.
//   clock, reset        : single clock, synchronous active-high reset
//   reqValid/reqReady   : request handshake; reqWrite, reqAddress, reqWriteData latched on acceptance
//   respValid/respReady : response handshake; respData (load result, 0 for stores), respError
//   memPosition, memWriteData, memWrite, memRead : data memory drive
//   memReadData         : data memory read data, valid the cycle after the memRead edge
//   busy                : unit is not idle
module load_store_unit #(
    parameter int MEM_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memPosition,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, oob;

    assign accept = reqValid & reqReady;

`ifdef DATA_BOUNDS_CHECK_EN
    assign oob = reqAddress >= 32'(MEM_DEPTH);
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                write_d = reqWrite;
                addr_d  = reqAddress;
                wdata_d = reqWriteData;
                rdata_d = '0;  // stores and rejected accesses report zero data
                err_d   = oob;
                state_d = oob ? RESP : ACCESS;
            end
            ACCESS: state_d = write_q ? RESP : WAIT;
            WAIT: begin
                rdata_d = memReadData;
                state_d = RESP;
            end
            RESP: state_d = respReady ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs are gated by reset so an in-flight access is dropped immediately.
    always_comb begin
        reqReady     = !reset && state_q == IDLE;
        memWrite     = !reset && state_q == ACCESS && write_q;
        memRead      = !reset && state_q == ACCESS && !write_q;
        respValid    = !reset && state_q == RESP;
        busy         = !reset && state_q != IDLE;
        respData     = rdata_q;
        respError    = err_q;
        memPosition  = addr_q & 32'(MEM_DEPTH - 1);
        memWriteData = wdata_q;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32: data-memory depth in 32-bit words; power of two.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port reqValid  input  1  request from execute stage is valid.
REQ-005 SHALL have port reqReady  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port reqWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port reqAddress  input  32  word index, as produced by the ALU.
REQ-008 SHALL have port reqWriteData  input  32  store data from the register file.
REQ-009 SHALL have port respValid  output  1  response available.
REQ-010 SHALL have port respReady  input  1  consumer (write-back mux) takes the response.
REQ-011 SHALL have port respData  output  32  load result; 0 for stores.
REQ-012 SHALL have port respError  output  1  access rejected (see Configuration).
REQ-013 SHALL have port memPosition  output  32  drives the data memory position input.
REQ-014 SHALL have port memWriteData  output  32  drives the data memory writeData input.
REQ-015 SHALL have port memWrite  output  1  data memory write strobe.
REQ-016 SHALL have port memRead  output  1  data memory read strobe.
REQ-017 SHALL have port memReadData  input  32  data memory readData, registered one cycle after the memRead edge.
REQ-018 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-020 SHALL assert reqReady only in IDLE with reset low; acceptance = reqValid & reqReady.
REQ-021 SHALL latch reqWrite, reqAddress, reqWriteData on acceptance and go to ACCESS; later changes on req* are ignored.
REQ-022 SHALL, in ACCESS, assert exactly one of memWrite (store) or memRead (load) for exactly one cycle, with memPosition/memWriteData from the latched values.
REQ-023 SHALL go from ACCESS to RESP for a store and to WAIT for a load.
REQ-024 SHALL, in WAIT, capture memReadData into respData and go to RESP.
REQ-025 SHALL hold memWrite = memRead = 0 in IDLE, WAIT and RESP; memPosition and memWriteData hold their latched values.
REQ-026 SHALL, in RESP, assert respValid with respData/respError stable until respReady = 1, then go to IDLE.
REQ-027 SHALL give latency, with acceptance at edge N: store respValid from cycle N+2; load respValid from cycle N+3.
REQ-028 SHALL NOT accept a new request in the cycle RESP exits; the next acceptance is no earlier than the following IDLE cycle.
REQ-029 SHALL drive respData = 0 for stores and for rejected accesses.

Reset
REQ-030 SHALL, while reset = 1, force reqReady, memWrite, memRead, respValid and busy to 0 combinationally.
REQ-031 SHALL, on a clock edge with reset = 1, set state IDLE and clear respData, respError and all latched registers to 0.
REQ-032 SHALL abort any in-flight request on reset: no memory strobe and no response for it afterwards.

Configuration
REQ-033 SHALL, with macro DATA_BOUNDS_CHECK_EN defined, check on acceptance for reqAddress >= MEM_DEPTH. A failing request skips ACCESS and WAIT, goes directly to RESP with respError = 1 and respData = 0, and issues no strobe; respValid appears in cycle N+1.
REQ-034 SHALL, without DATA_BOUNDS_CHECK_EN, drive memPosition = reqAddress mod MEM_DEPTH (wrap-around), tie respError to 0, and perform every access.

Verification
REQ-035 SHALL cover: reset, then load address 5 -> single-cycle memRead with memPosition = 5; respValid in cycle N+3 with respData = 5 (memory reset contents).
REQ-036 SHALL cover: store 0xDEADBEEF to 7, then load 7 -> memWrite high exactly one cycle; load returns 0xDEADBEEF; store respData = 0.
REQ-037 SHALL cover: respReady held low 4 cycles during RESP with reqValid = 1 -> respValid/respData stable, reqReady = 0, second request accepted only after release.
REQ-038 SHALL cover: load address 40 -> with DATA_BOUNDS_CHECK_EN: respError = 1, no strobe, respValid at N+1; without: memPosition = 8, respData = 8.
REQ-039 SHALL cover: reset asserted in the ACCESS cycle of a store to address 3 -> no memWrite after reset, state IDLE, respValid = 0, memory[3] = 3.
